// File: rtl/vpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the A-tile loader,
// the W-tile loader and the result store. Each grant owns the port for a
// fixed burst of BURST_LEN consecutive addresses; one IDLE cycle always
// separates bursts.
module vpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int BUS_WIDTH  = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  req_w,
  input  logic                  req_r,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [ADDR_WIDTH-1:0] addr_res,
  input  logic [BUS_WIDTH-1:0]  wdata_res,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  output logic                  gnt_a,
  output logic                  gnt_w,
  output logic                  gnt_r,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0]  mem_wdata,
  output logic                  beat_ack,
  output logic [BUS_WIDTH-1:0]  rdata,
  output logic                  rvalid_a,
  output logic                  rvalid_w,
  output logic                  done,
  output logic                  busy
);

  localparam int            CW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q;
  logic [1:0]            ptr_q, ptr_d;     // 0 = A, 1 = W, 2 = R
  logic [CW-1:0]         beat_q;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  gnt_a_q, gnt_w_q, gnt_r_q, busy_q;
  logic                  rvalid_a_q, rvalid_w_q;
  logic                  win_a, win_w, win_r;
  logic                  last_beat;

  // Pick the first requester at or after the pointer; the pointer then
  // moves past the winner so nobody holds a fixed priority.
  always_comb begin
    win_a = 1'b0;
    win_w = 1'b0;
    win_r = 1'b0;
    case (ptr_q)
      2'd1: begin
        if (req_w)      win_w = 1'b1;
        else if (req_r) win_r = 1'b1;
        else if (req_a) win_a = 1'b1;
      end
      2'd2: begin
        if (req_r)      win_r = 1'b1;
        else if (req_a) win_a = 1'b1;
        else if (req_w) win_w = 1'b1;
      end
      default: begin
        if (req_a)      win_a = 1'b1;
        else if (req_w) win_w = 1'b1;
        else if (req_r) win_r = 1'b1;
      end
    endcase
    ptr_d = ptr_q;
    if (win_a)      ptr_d = 2'd1;
    else if (win_w) ptr_d = 2'd2;
    else if (win_r) ptr_d = 2'd0;
    base_d = win_a ? addr_a : (win_w ? addr_w : addr_res);
  end

  // Burst FSM: arbitrate only in IDLE, then run exactly BURST_LEN beats
  // regardless of what the requesters or base addresses do meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      beat_q  <= '0;
      base_q  <= '0;
      gnt_a_q <= 1'b0;
      gnt_w_q <= 1'b0;
      gnt_r_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_a | req_w | req_r) begin
            state_q <= BURST;
            ptr_q   <= ptr_d;
            beat_q  <= '0;
            base_q  <= base_d;
            gnt_a_q <= win_a;
            gnt_w_q <= win_w;
            gnt_r_q <= win_r;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          if (last_beat) begin
            state_q <= IDLE;
            beat_q  <= '0;
            gnt_a_q <= 1'b0;
            gnt_w_q <= 1'b0;
            gnt_r_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Read-valid follows a read access by one cycle, matching memory latency;
  // reset clears it so an aborted read never reports data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_a_q <= 1'b0;
      rvalid_w_q <= 1'b0;
    end else begin
      rvalid_a_q <= mem_en & ~mem_we & gnt_a_q;
      rvalid_w_q <= mem_en & ~mem_we & gnt_w_q;
    end
  end

  // Port outputs decode from registered state only; everything is zero
  // outside a burst.
  assign last_beat = (beat_q == LAST);
  assign gnt_a     = gnt_a_q;
  assign gnt_w     = gnt_w_q;
  assign gnt_r     = gnt_r_q;
  assign busy      = busy_q;
  assign mem_en    = busy_q;
  assign mem_we    = busy_q & gnt_r_q;
  assign beat_ack  = busy_q & gnt_r_q;
  assign done      = busy_q & last_beat;
  assign mem_addr  = busy_q ? (base_q + ADDR_WIDTH'(beat_q)) : '0;
  assign mem_wdata = (busy_q & gnt_r_q) ? wdata_res : '0;
  assign rdata     = mem_rdata;
  assign rvalid_a  = rvalid_a_q;
  assign rvalid_w  = rvalid_w_q;

endmodule
